// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, ALU format encodings, sequencer FSM states and
// immediate-extension kinds shared by the execute sequencer and its regfile.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_SLL  = 6'd0;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_JR   = 6'd8;
    localparam logic [5:0] F_MULT = 6'd24;
    localparam logic [5:0] F_MULTU= 6'd25;
    localparam logic [5:0] F_DIV  = 6'd26;
    localparam logic [5:0] F_DIVU = 6'd27;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_ADDU = 6'd33;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_SUBU = 6'd35;
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] F_SLTU = 6'd43;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RETIRE} state_e;
    typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_UPPER} imm_kind_e;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            F_SLL, F_SRL, F_JR, F_MULT, F_MULTU, F_DIV, F_DIVU, F_ADD, F_ADDU,
            F_SUB, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic iop_ok(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two registered read ports (loaded when re_i is high),
// one write port, one combinational debug port. x0 always reads as zero.
module mips_regfile #(
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  dbg_addr_i,
    output logic [31:0] dbg_data_o
);
    logic [31:0] mem_q [32];

    generate
        if (CLEAR_ON_RST) begin : g_clr
            // Storage write; whole array cleared on reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) mem_q[i] <= '0;
                end else if (we_i && wa_i != 5'd0) begin
                    mem_q[wa_i] <= wd_i;
                end
            end
        end else begin : g_noclr
            // Storage write; contents survive reset, x0 masked on read
            always_ff @(posedge clk) begin
                if (we_i && wa_i != 5'd0) mem_q[wa_i] <= wd_i;
            end
        end
    endgenerate

    // Synchronous operand read, held between loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_o <= '0;
            rd2_o <= '0;
        end else if (re_i) begin
            rd1_o <= (ra1_i == 5'd0) ? '0 : mem_q[ra1_i];
            rd2_o <= (ra2_i == 5'd0) ? '0 : mem_q[ra2_i];
        end
    end

    assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_seq.sv
// Multi-cycle execute sequencer: IDLE -> DECODE -> EXEC -> RETIRE.
// Operands are read from the regfile on the accept edge so they are present
// in DECODE, where the op is classified and the ALU inputs are registered.
// Optional feature macro: ILLEGAL_TRAP_EN (trap unsupported opcode/funct).
module alu_issue_seq #(
    parameter int DATA_W          = 32,
    parameter bit RF_CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [5:0]        alu_f_code,
    output logic [1:0]        alu_format,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] res_data,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic              ea_valid,
    output logic              jump_valid,
    output logic              div0,
    output logic              illegal,
    output logic              done,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import mips_isa_pkg::*;

    state_e            state_q, state_d;
    logic [31:0]       instr_q;
    logic              accept;
    logic [DATA_W-1:0] rs_val, rt_val;

    logic [5:0]  op, funct;
    logic [4:0]  rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    assign op     = instr_q[31:26];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign funct  = instr_q[5:0];
    assign imm    = instr_q[15:0];
    assign target = instr_q[25:0];

    logic [1:0]        fmt_c;
    logic [5:0]        fc_c;
    logic [DATA_W-1:0] d1_c, d2_c;
    logic [4:0]        dst_c;
    logic              we_c, ea_c, jmp_c, isdiv_c, dz_c, ill_c;
    imm_kind_e         kind_c;

    logic [4:0] dst_q;
    logic       we_q, ea_q, jmp_q, dz_q, ill_q;

    assign accept = (state_q == S_IDLE) && instr_valid;

    mips_regfile #(.CLEAR_ON_RST(RF_CLEAR_ON_RST)) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .re_i       (accept),
        .ra1_i      (instr[25:21]),
        .ra2_i      (instr[20:16]),
        .rd1_o      (rs_val),
        .rd2_o      (rt_val),
        .we_i       (wb_we),
        .wa_i       (wb_addr),
        .wd_i       (res_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; only IDLE accepts
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_RETIRE;
            S_RETIRE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Classify the latched instruction and shape the ALU operands
    always_comb begin
        fmt_c   = FMT_I;
        fc_c    = op;
        d1_c    = rs_val;
        d2_c    = rt_val;
        dst_c   = rt;
        we_c    = 1'b1;
        ea_c    = 1'b0;
        jmp_c   = 1'b0;
        isdiv_c = 1'b0;
        ill_c   = 1'b0;
        kind_c  = IMM_SIGN;
        if (op == OP_RTYPE) begin
            fmt_c   = FMT_R;
            fc_c    = funct;
            dst_c   = rd;
            isdiv_c = (funct == F_DIV) || (funct == F_DIVU);
            if (funct == F_JR) begin
                we_c  = 1'b0;
                jmp_c = 1'b1;
            end
        end else if (op == OP_J) begin
            fmt_c = FMT_J;
            fc_c  = OP_J;
            d1_c  = '0;
            d2_c  = {4'b0, target, 2'b0};
            we_c  = 1'b0;
            jmp_c = 1'b1;
        end else begin
            case (op)
                OP_ANDI, OP_ORI: kind_c = IMM_ZERO;
                OP_LUI:          kind_c = IMM_UPPER;
                default:         kind_c = IMM_SIGN;
            endcase
            case (kind_c)
                IMM_ZERO:  d2_c = {16'h0, imm};
                IMM_UPPER: d2_c = {imm, 16'h0};
                default:   d2_c = {{16{imm[15]}}, imm};
            endcase
            if (op == OP_LW || op == OP_SW) begin
                we_c = 1'b0;
                ea_c = 1'b1;
            end
        end
`ifdef ILLEGAL_TRAP_EN
        ill_c = (op == OP_RTYPE) ? !funct_ok(funct) : (op != OP_J && !iop_ok(op));
        if (ill_c) {we_c, ea_c, jmp_c, isdiv_c} = '0;
`endif
        if (dst_c == 5'd0) we_c = 1'b0;
        dz_c = isdiv_c && (rs_val == '0 || rt_val == '0);
    end

    // Instruction latch and DECODE-stage issue registers (alu_* hold outside EXEC)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            alu_f_code <= '0;
            alu_format <= '0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            dst_q      <= '0;
            {we_q, ea_q, jmp_q, dz_q, ill_q} <= '0;
        end else begin
            if (accept) instr_q <= instr;
            if (state_q == S_DECODE) begin
                alu_f_code <= fc_c;
                alu_format <= fmt_c;
                alu_data1  <= d1_c;
                alu_data2  <= d2_c;
                dst_q      <= dst_c;
                {we_q, ea_q, jmp_q, dz_q, ill_q} <= {we_c, ea_c, jmp_c, dz_c, ill_c};
            end
        end
    end

    // Retire: capture ALU result at end of EXEC, pulses live for RETIRE only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            wb_addr  <= '0;
            {wb_we, ea_valid, jump_valid, div0, illegal, done} <= '0;
        end else begin
            {wb_we, ea_valid, jump_valid, div0, illegal, done} <= '0;
            if (state_q == S_EXEC) begin
                res_data   <= dz_q ? '0 : alu_result;
                wb_addr    <= dst_q;
                wb_we      <= we_q;
                ea_valid   <= ea_q;
                jump_valid <= jmp_q;
                div0       <= dz_q;
                illegal    <= ill_q;
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a small combinational ALU model.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [5:0]  alu_f_code;
    logic [1:0]  alu_format;
    logic [31:0] alu_data1, alu_data2, alu_result, res_data, dbg_data;
    logic        wb_we, ea_valid, jump_valid, div0, illegal, done;
    logic [4:0]  wb_addr;
    logic [4:0]  dbg_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // snapshot of the last issued instruction
    int          s_rdy_low;
    logic [1:0]  s_fmt;
    logic [5:0]  s_fc;
    logic [31:0] s_d1, s_d2, s_res;
    logic        s_we, s_ea, s_jmp, s_dz, s_ill, s_done;
    logic [4:0]  s_addr;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_f_code(alu_f_code), .alu_format(alu_format),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_result(alu_result),
        .res_data(res_data), .wb_we(wb_we), .wb_addr(wb_addr), .ea_valid(ea_valid),
        .jump_valid(jump_valid), .div0(div0), .illegal(illegal), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ALU model (divide by zero returns a marker the sequencer must squash)
    always_comb begin
        alu_result = 32'h0;
        case (alu_format)
            2'd0: case (alu_f_code)
                6'd32, 6'd33: alu_result = alu_data1 + alu_data2;
                6'd34, 6'd35: alu_result = alu_data1 - alu_data2;
                6'd36:        alu_result = alu_data1 & alu_data2;
                6'd37:        alu_result = alu_data1 | alu_data2;
                6'd26, 6'd27: alu_result = (alu_data2 == 0) ? 32'hBAD0_0000 : alu_data1 / alu_data2;
                default:      alu_result = 32'h0;
            endcase
            2'd1: case (alu_f_code)
                6'd8, 6'd9, 6'd35, 6'd43: alu_result = alu_data1 + alu_data2;
                6'd12:   alu_result = alu_data1 & alu_data2;
                6'd13:   alu_result = alu_data1 | alu_data2;
                6'd15:   alu_result = alu_data2;
                default: alu_result = 32'h0000_0A5A;
            endcase
            2'd2:    alu_result = alu_data2;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction
    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int im);
        return {op[5:0], rs[4:0], rt[4:0], im[15:0]};
    endfunction

    // Drive one instruction through the handshake and snapshot EXEC/RETIRE.
    task automatic run(input logic [31:0] ins);
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = '0;
        s_rdy_low = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (!instr_ready) s_rdy_low++;
            if (k == 2) begin
                s_fmt = alu_format; s_fc = alu_f_code; s_d1 = alu_data1; s_d2 = alu_data2;
            end
            if (k == 3) begin
                s_done = done; s_we = wb_we; s_addr = wb_addr; s_res = res_data;
                s_ea = ea_valid; s_jmp = jump_valid; s_dz = div0; s_ill = illegal;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        dbg_addr = a[4:0];
        #1 v = dbg_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        n_tests++; if ({done, wb_we, ea_valid, jump_valid, div0, illegal} !== 6'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0", {done, wb_we, ea_valid, jump_valid, div0, illegal}); end
        n_tests++; if (res_data !== 32'h0 || alu_data1 !== 32'h0 || alu_f_code !== 6'h0) begin n_fail++; $display("FAIL reset_data got res=%h d1=%h fc=%h want 0", res_data, alu_data1, alu_f_code); end
        rst_n = 1'b1;
        run(itype(8, 0, 1, 7));
        run(itype(8, 0, 2, 5));
        rd(1, v);
        n_tests++; if (v !== 32'd7) begin n_fail++; $display("FAIL preload_x1 got %h want 7", v); end
        rd(2, v);
        n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL preload_x2 got %h want 5", v); end
    endtask

    task automatic test_add;
        logic [31:0] v;
        run(rtype(1, 2, 3, 32));
        n_tests++; if (s_fmt !== 2'd0 || s_fc !== 6'd32) begin n_fail++; $display("FAIL add_issue got fmt=%0d fc=%0d want 0/32", s_fmt, s_fc); end
        n_tests++; if (s_d1 !== 32'd7 || s_d2 !== 32'd5) begin n_fail++; $display("FAIL add_operands got %h %h want 7 5", s_d1, s_d2); end
        n_tests++; if (!(s_done === 1'b1 && s_we === 1'b1 && s_addr === 5'd3 && s_res === 32'd12)) begin n_fail++; $display("FAIL add_retire got done=%b we=%b addr=%0d res=%h want 1 1 3 c", s_done, s_we, s_addr, s_res); end
        rd(3, v);
        n_tests++; if (v !== 32'd12) begin n_fail++; $display("FAIL add_x3 got %h want c", v); end
        repeat (2) @(negedge clk);
        n_tests++; if (res_data !== 32'd12 || done !== 1'b0) begin n_fail++; $display("FAIL res_hold got res=%h done=%b want c 0", res_data, done); end
    endtask

    task automatic test_imm;
        logic [31:0] v;
        run(itype(8, 0, 4, 16'hFFFF));
        n_tests++; if (s_fmt !== 2'd1 || s_fc !== 6'd8 || s_d2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_issue got fmt=%0d fc=%0d d2=%h want 1 8 ffffffff", s_fmt, s_fc, s_d2); end
        n_tests++; if (s_rdy_low != 3) begin n_fail++; $display("FAIL addi_ready_low got %0d want 3", s_rdy_low); end
        rd(4, v);
        n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_x4 got %h want ffffffff", v); end
        run(itype(13, 0, 5, 16'hFFFF));
        n_tests++; if (s_d2 !== 32'h0000_FFFF || s_rdy_low != 3) begin n_fail++; $display("FAIL ori_issue got d2=%h rdylow=%0d want 0000ffff 3", s_d2, s_rdy_low); end
        rd(5, v);
        n_tests++; if (v !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ori_x5 got %h want 0000ffff", v); end
        run(itype(15, 0, 9, 16'h1234));
        rd(9, v);
        n_tests++; if (v !== 32'h1234_0000) begin n_fail++; $display("FAIL lui_x9 got %h want 12340000", v); end
    endtask

    task automatic test_div;
        logic [31:0] v;
        run(rtype(1, 0, 6, 26));
        n_tests++; if (!(s_dz === 1'b1 && s_res === 32'h0 && s_we === 1'b1 && s_addr === 5'd6)) begin n_fail++; $display("FAIL div0_retire got div0=%b res=%h we=%b addr=%0d want 1 0 1 6", s_dz, s_res, s_we, s_addr); end
        rd(6, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL div0_x6 got %h want 0", v); end
        run(rtype(1, 2, 7, 27));
        n_tests++; if (s_dz !== 1'b0 || s_res !== 32'd1) begin n_fail++; $display("FAIL divu_retire got div0=%b res=%h want 0 1", s_dz, s_res); end
        rd(7, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL divu_x7 got %h want 1", v); end
    endtask

    task automatic test_mem_jump;
        run(itype(43, 1, 2, 4));
        n_tests++; if (!(s_ea === 1'b1 && s_res === 32'd11 && s_we === 1'b0 && s_jmp === 1'b0)) begin n_fail++; $display("FAIL sw_retire got ea=%b res=%h we=%b jmp=%b want 1 b 0 0", s_ea, s_res, s_we, s_jmp); end
        run({6'd2, 26'h100});
        n_tests++; if (s_fmt !== 2'd2 || s_fc !== 6'd2 || s_d2 !== 32'h400) begin n_fail++; $display("FAIL j_issue got fmt=%0d fc=%0d d2=%h want 2 2 400", s_fmt, s_fc, s_d2); end
        n_tests++; if (!(s_jmp === 1'b1 && s_res === 32'h400 && s_we === 1'b0 && s_ea === 1'b0)) begin n_fail++; $display("FAIL j_retire got jmp=%b res=%h we=%b ea=%b want 1 400 0 0", s_jmp, s_res, s_we, s_ea); end
    endtask

    task automatic test_x0_write;
        logic [31:0] v;
        run(rtype(1, 2, 0, 32));
        n_tests++; if (s_done !== 1'b1 || s_we !== 1'b0) begin n_fail++; $display("FAIL x0_retire got done=%b we=%b want 1 0", s_done, s_we); end
        rd(0, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL x0_value got %h want 0", v); end
    endtask

    task automatic test_illegal;
        logic [31:0] v;
        run(itype(6'h3F, 0, 10, 5));
        rd(10, v);
`ifdef ILLEGAL_TRAP_EN
        n_tests++; if (!(s_ill === 1'b1 && s_done === 1'b1 && {s_we, s_ea, s_jmp, s_dz} === 4'b0)) begin n_fail++; $display("FAIL illegal_trap got ill=%b done=%b others=%b want 1 1 0", s_ill, s_done, {s_we, s_ea, s_jmp, s_dz}); end
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL illegal_x10 got %h want 0", v); end
`else
        n_tests++; if (!(s_ill === 1'b0 && s_done === 1'b1 && s_we === 1'b1 && s_addr === 5'd10)) begin n_fail++; $display("FAIL illegal_pass got ill=%b done=%b we=%b addr=%0d want 0 1 1 10", s_ill, s_done, s_we, s_addr); end
        n_tests++; if (v !== 32'h0000_0A5A) begin n_fail++; $display("FAIL illegal_x10 got %h want a5a", v); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        int ndone;
        @(negedge clk);
        instr = rtype(1, 2, 8, 32);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (alu_f_code !== 6'd32) begin n_fail++; $display("FAIL mid_exec got fc=%0d want 32", alu_f_code); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (instr_ready !== 1'b1 || wb_we !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_abort got ready=%b we=%b done=%b want 1 0 0", instr_ready, wb_we, done); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_tests++; if (ndone != 0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_retire got done_cnt=%0d ready=%b want 0 1", ndone, instr_ready); end
        rd(8, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_x8 got %h want 0", v); end
        rd(1, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_rf_clear got %h want 0", v); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_imm;
        test_div;
        test_mem_jump;
        test_x0_write;
        test_illegal;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Multi-cycle execute sequencer that drives the datapath ALU's f_code/format/data1/data2 inputs and consumes its combinational result.
- Accepts one 32-bit MIPS instruction per valid/ready handshake and reads operands from an internal 32x32 register file.
- Shapes immediates, issues the op to the ALU, then retires the result: register writeback, effective address for lw/sw, or jump target.
- Sits between the fetch stage and the ALU.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- RF_CLEAR_ON_RST, 1, when 1 all registers reset to 0; when 0 only x0 is forced to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr  in  32  MIPS instruction word.
- alu_f_code  out  6  to ALU: funct (R-type) or opcode (I/J-type).
- alu_format  out  2  to ALU: 0=R, 1=I, 2=J.
- alu_data1  out  32  to ALU operand 1.
- alu_data2  out  32  to ALU operand 2.
- alu_result  in  32  from ALU, combinational.
- res_data  out  32  retired result.
- wb_we  out  1  pulse: register written.
- wb_addr  out  5  destination register.
- ea_valid  out  1  pulse: res_data is a lw/sw address.
- jump_valid  out  1  pulse: res_data is a jump target.
- div0  out  1  pulse: divide with a zero operand.
- illegal  out  1  pulse: unsupported op (ILLEGAL_TRAP_EN only).
- done  out  1  pulse: instruction retired.
- dbg_addr  in  5  bench register-read address.
- dbg_data  out  32  combinational read of dbg_addr.

Behaviour:
- Reset values: all outputs 0 except instr_ready, which is 1; FSM in IDLE.
- FSM states: IDLE -> DECODE -> EXEC -> RETIRE -> IDLE.
  - IDLE: instr_ready=1. On instr_valid, latch instr and go to DECODE. instr_ready is 0 in every other state.
  - DECODE: register file synchronous read of rs and rt; classify the op; latch the operands.
  - EXEC: drive registered alu_* outputs; sample alu_result at the end of the cycle.
  - RETIRE: register write and all pulses assert for exactly one cycle; done=1.
- Latency: handshake to done is 3 cycles. Throughput is one instruction per 4 cycles.
- alu_* outputs hold their last value outside EXEC.
- R-type (opcode 0):
  - format=0, f_code=funct, data1=rs, data2=rt, write to rd.
  - Supported funct: 0,2,8,24,25,26,27,32,33,34,35,36,37,42,43.
  - funct 8 (jr): no write; jump_valid.
- I-type:
  - format=1, f_code=opcode, data1=rs.
  - data2 is sign-extended imm for 8,9,10,11,35,43; zero-extended for 12,13; {imm,16'h0} for 15.
  - Write to rt, except 35/43 (lw/sw): no write; ea_valid.
- J (opcode 2): format=2, f_code=2, data2={4'b0,target,2'b0}; no write; jump_valid.
- Divide (funct 26/27) with rs==0 or rt==0: result forced to 0, written to rd, div0 pulses.
- Writes to x0 are discarded: wb_we stays 0; done still pulses.
- res_data is held until the next RETIRE.
- Reset asserted mid-operation: abort immediately, return to IDLE, no partial write, register file cleared per RF_CLEAR_ON_RST.
- instr_valid deasserting outside IDLE is ignored.

Optional Feature:
- ILLEGAL_TRAP_EN
  - Defined: an unsupported opcode/funct pulses illegal in RETIRE, suppresses every write/ea/jump, and still pulses done.
  - Undefined: unsupported ops are issued to the ALU unchanged and retired as the R/I rules dictate; illegal is tied to 0.

Decomposition:
- Package mips_isa_pkg:
  - opcode and funct constants.
  - format encodings FMT_R/FMT_I/FMT_J.
  - FSM state enum.
  - imm-extension kind enum.
- Sub-module mips_regfile:
  - 32x32, two synchronous read ports, one write port, one combinational debug port.
  - x0 hardwired to 0.
  - Asynchronous active-low reset.

Test Plan:
1. Reset with x1=7, x2=5 preloaded; issue add x3,x1,x2 (funct 32) -> alu_format=0, alu_f_code=32 during EXEC; wb_we, wb_addr=3, res_data=12, done 3 cycles after the handshake; dbg x3=12.
2. addi x4,x0,-1 then ori x5,x0,0xFFFF -> x4=0xFFFFFFFF (sign-extended); x5=0x0000FFFF (zero-extended); instr_ready low for 3 cycles after each accept.
3. div x6,x1,x0 (funct 26) -> div0 pulse, x6=0; then divu x7,x1,x2 with 7,5 -> x7=1, no div0.
4. sw with rs=x1=7, imm=4 -> ea_valid pulse, res_data=11, wb_we=0; j target=0x100 -> jump_valid, res_data=0x400.
5. add x0,x1,x2 -> done pulses, wb_we=0, x0 remains 0; rst_n asserted during EXEC of add x8 -> no write to x8, instr_ready=1 on release.
6. With ILLEGAL_TRAP_EN: opcode 0x3F -> illegal and done pulse, no other pulse; without the macro -> illegal stays 0.
